// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, reset PC
// default, the NOP word used to clear inst_out, and the alignment test.
package if_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0000;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    VALID = 3'd2,
    DRAIN = 3'd3,
    ERR   = 3'd4
  } state_e;

  // Instructions are word aligned; any low-bit set is a fetch fault.
  function automatic logic misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_unit_pc_reg.sv
// Load-enable register holding the fetch PC.
// Ports: clk, rst_n (async, active low), load (enable), d (new value),
//        q (current value, RESET_PC after reset).
module if_fetch_unit_pc_reg #(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) q_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RESET_PC;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: holds the PC, runs one req/ack instruction-memory transaction
// per instruction and hands the word plus its PC to ID with valid/stall.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   next_pc               next PC from the upstream mux
//   redirect              load next_pc now, drop any in-flight instruction
//   stall                 ID cannot accept; hold the presented instruction
//   imem_req/imem_addr    memory request and its address (= pc)
//   imem_ack/imem_rdata   memory response
//   inst_valid/inst_out/pc_out  instruction presented to ID
//   addr_err              fetch halted on a misaligned PC
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] next_pc,
  input  logic             redirect,
  input  logic             stall,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst_out,
  output logic [WIDTH-1:0] pc_out,
  output logic             addr_err
);

  state_e           state_q, state_d;
  logic             pc_load;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] pc_q;
  // Redirect target parked while an abandoned request drains; pc itself keeps
  // the old address so imem_addr stays stable with imem_req high.
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             inst_valid_q, inst_valid_d;
  logic [WIDTH-1:0] inst_out_q, inst_out_d;
  logic [WIDTH-1:0] pc_out_q, pc_out_d;

  if_fetch_unit_pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pc_load),
    .d     (pc_nxt),
    .q     (pc_q)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      tgt_q        <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_out_q   <= WIDTH'(INST_NOP);
      pc_out_q     <= RESET_PC;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      pc_out_q     <= pc_out_d;
    end
  end

  // Next state and register updates; redirect wins in every state
  always_comb begin
    state_d      = state_q;
    pc_load      = 1'b0;
    pc_nxt       = next_pc;
    tgt_d        = tgt_q;
    inst_valid_d = inst_valid_q;
    inst_out_d   = inst_out_q;
    pc_out_d     = pc_out_q;
    unique case (state_q)
      BOOT: begin
        if (redirect) begin
          pc_load = 1'b1;
          state_d = misaligned(next_pc[1:0]) ? ERR : FETCH;
        end else begin
          state_d = misaligned(pc_q[1:0]) ? ERR : FETCH;
        end
      end
      FETCH: begin
        if (redirect) begin
          inst_valid_d = 1'b0;
          if (imem_ack) begin
            pc_load = 1'b1;
            state_d = misaligned(next_pc[1:0]) ? ERR : FETCH;
          end else begin
            tgt_d   = next_pc;
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          inst_out_d   = imem_rdata;
          pc_out_d     = pc_q;
          inst_valid_d = 1'b1;
          state_d      = VALID;
        end
      end
      VALID: begin
        if (redirect || !stall) begin
          pc_load      = 1'b1;
          inst_valid_d = 1'b0;
          state_d      = misaligned(next_pc[1:0]) ? ERR : FETCH;
        end
      end
      DRAIN: begin
        if (redirect) tgt_d = next_pc;
        if (imem_ack) begin
          pc_load = 1'b1;
          pc_nxt  = redirect ? next_pc : tgt_q;
          state_d = misaligned(pc_nxt[1:0]) ? ERR : FETCH;
        end
      end
      ERR: begin
        if (redirect && !misaligned(next_pc[1:0])) begin
          pc_load = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Outputs decoded from state or taken straight from registers
  always_comb begin
    imem_req   = (state_q == FETCH) || (state_q == DRAIN);
    addr_err   = (state_q == ERR);
    imem_addr  = pc_q;
    inst_valid = inst_valid_q;
    inst_out   = inst_out_q;
    pc_out     = pc_out_q;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        redirect;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        addr_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .WIDTH    (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .next_pc    (next_pc),
    .redirect   (redirect),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .pc_out     (pc_out),
    .addr_err   (addr_err)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; next_pc = '0; redirect = 1'b0; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    #12;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", inst_out); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", addr_err); end
    checks++; if (pc_out !== RST_PC) begin errors++; $display("FAIL reset_pc_out got=%h exp=%h", pc_out, RST_PC); end
    checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RST_PC); end
    tick();
    rst_n = 1'b1;
    tick(); // BOOT -> FETCH
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC + 32'(4*k))
        begin errors++; $display("FAIL seq_req[%0d] got=%b/%h exp=1/%h", k, imem_req, imem_addr, RST_PC + 32'(4*k)); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL seq_nvalid[%0d] got=%b exp=0", k, inst_valid); end
      imem_ack = 1'b1; imem_rdata = 32'h1000 + 32'(k);
      tick();
      imem_ack = 1'b0;
      checks++; if (inst_valid !== 1'b1 || inst_out !== 32'h1000 + 32'(k) || pc_out !== RST_PC + 32'(4*k) || imem_req !== 1'b0)
        begin errors++; $display("FAIL seq_valid[%0d] got=%b/%h/%h/%b exp=1/%h/%h/0", k, inst_valid, inst_out, pc_out, imem_req, 32'h1000 + 32'(k), RST_PC + 32'(4*k)); end
      next_pc = RST_PC + 32'(4*(k+1));
      tick();
    end
  endtask

  task automatic test_stall();
    imem_ack = 1'b1; imem_rdata = 32'hA5A5_A5A5;
    tick();
    imem_ack = 1'b0; stall = 1'b1; next_pc = RST_PC + 32'h10;
    for (int c = 0; c < 5; c++) begin
      checks++; if (inst_valid !== 1'b1 || inst_out !== 32'hA5A5_A5A5 || pc_out !== RST_PC + 32'hC || imem_req !== 1'b0)
        begin errors++; $display("FAIL stall_hold[%0d] got=%b/%h/%h/%b exp=1/a5a5a5a5/%h/0", c, inst_valid, inst_out, pc_out, imem_req, RST_PC + 32'hC); end
      tick();
    end
    stall = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC + 32'h10 || inst_valid !== 1'b0)
      begin errors++; $display("FAIL stall_release got=%b/%h/%b exp=1/%h/0", imem_req, imem_addr, inst_valid, RST_PC + 32'h10); end
  endtask

  task automatic test_redirect_drain();
    redirect = 1'b1; next_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC + 32'h10 || inst_valid !== 1'b0)
        begin errors++; $display("FAIL drain_hold[%0d] got=%b/%h/%b exp=1/%h/0", c, imem_req, imem_addr, inst_valid, RST_PC + 32'h10); end
      if (c < 2) tick();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0 || inst_out !== 32'hA5A5_A5A5)
        begin errors++; $display("FAIL drain_refetch[%0d] got=%b/%h/%b/%h exp=1/100/0/a5a5a5a5", c, imem_req, imem_addr, inst_valid, inst_out); end
      tick();
    end
  endtask

  task automatic test_redirect_ack_same();
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678; redirect = 1'b1; next_pc = 32'h0000_0300;
    tick();
    imem_ack = 1'b0; redirect = 1'b0;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300 || inst_out !== 32'hA5A5_A5A5)
      begin errors++; $display("FAIL redir_ack got=%b/%b/%h/%h exp=0/1/300/a5a5a5a5", inst_valid, imem_req, imem_addr, inst_out); end
  endtask

  task automatic test_misaligned();
    imem_ack = 1'b1; imem_rdata = 32'h77;
    tick();
    imem_ack = 1'b0; stall = 1'b1;
    redirect = 1'b1; next_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0; stall = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++; if (addr_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0)
        begin errors++; $display("FAIL misalign[%0d] got=%b/%b/%b exp=1/0/0", c, addr_err, imem_req, inst_valid); end
      tick();
    end
    redirect = 1'b1; next_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    checks++; if (addr_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200)
      begin errors++; $display("FAIL err_exit got=%b/%b/%h exp=0/1/200", addr_err, imem_req, imem_addr); end
  endtask

  task automatic test_redirect_over_stall();
    imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D;
    tick();
    imem_ack = 1'b0; stall = 1'b1;
    checks++; if (inst_valid !== 1'b1 || inst_out !== 32'h0BAD_F00D || pc_out !== 32'h200)
      begin errors++; $display("FAIL fetch_200 got=%b/%h/%h exp=1/0badf00d/200", inst_valid, inst_out, pc_out); end
    redirect = 1'b1; next_pc = 32'h0000_0204;
    tick();
    redirect = 1'b0; stall = 1'b0;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h204)
      begin errors++; $display("FAIL redir_stall got=%b/%b/%h exp=0/1/204", inst_valid, imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || addr_err !== 1'b0 || pc_out !== RST_PC || imem_addr !== RST_PC)
      begin errors++; $display("FAIL reset_mid got=%b/%b/%b/%h/%h exp=0/0/0/%h/%h", imem_req, inst_valid, addr_err, pc_out, imem_addr, RST_PC, RST_PC); end
    tick();
    rst_n = 1'b1;
    begin
      int n = 0;
      while (imem_req !== 1'b1 && n < 10) begin tick(); n++; end
      checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC)
        begin errors++; $display("FAIL reset_restart got=%b/%h exp=1/%h", imem_req, imem_addr, RST_PC); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_drain();
    test_redirect_ack_same();
    test_misaligned();
    test_redirect_over_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
